// File: rtl/hsst_tx_lane_arbiter.sv
// Round-robin TX scheduler for one 32-bit HSST lane: frames packets from NUM_REQ sources between K28.5 idles.
// Optional source header word before each packet when HSST_TX_SRC_TAG_EN is defined.
module hsst_tx_lane_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 256,
    parameter int IDLE_GAP  = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            txdata,
    output logic [3:0]             txk,
    output logic [1:0]             grant_id,
    output logic                   tx_busy,
    output logic                   underrun
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [31:0] IDLE_WORD = 32'hBCBCBCBC;

    typedef enum logic [1:0] {ST_GAP, ST_ARB, ST_TAG, ST_DATA} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      grant_reg, grant_next;
    logic [1:0]      ptr_reg, ptr_next;
    logic [31:0]     txdata_reg, txdata_next;
    logic [3:0]      txk_reg, txk_next;
    logic            underrun_reg, underrun_next;

    logic [31:0]            src_word [NUM_REQ];
    logic                   xfer;
    logic                   sel_last;
    logic [31:0]            sel_data;
    logic [CW-1:0]          cnt_inc;
    logic [2*NUM_REQ-1:0]   valid_rot;
    logic                   hit;
    logic [1:0]             hit_idx;

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign src_word[gi]  = req_data[32*gi +: 32];
            assign req_ready[gi] = (state_reg == ST_DATA) && (grant_reg == 2'(gi));
        end
    endgenerate

    // req_ready is one-hot on the granted source, so it doubles as the data/last select
    assign xfer     = |(req_valid & req_ready);
    assign sel_last = |(req_last & req_ready);
    assign cnt_inc  = cnt_reg + CW'(1);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) sel_data = src_word[i];
        end
    end

    // Rotate valids so bit 0 is the source at the round-robin pointer
    assign valid_rot = {req_valid, req_valid} >> ptr_reg;

    always_comb begin
        hit     = 1'b0;
        hit_idx = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && valid_rot[k]) begin
                hit     = 1'b1;
                hit_idx = wrap_add(ptr_reg, k);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        cnt_next      = cnt_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        txdata_next   = IDLE_WORD;
        txk_next      = 4'b1111;
        underrun_next = 1'b0;
        case (state_reg)
            ST_GAP: begin
                if (gap_cnt_reg == GW'(IDLE_GAP - 1)) begin
                    state_next   = ST_ARB;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            ST_ARB: begin
                if (hit) begin
                    grant_next = hit_idx;
                    ptr_next   = wrap_add(hit_idx, 1);
`ifdef HSST_TX_SRC_TAG_EN
                    state_next = ST_TAG;
`else
                    state_next = ST_DATA;
                    cnt_next   = '0;
`endif
                end
            end
`ifdef HSST_TX_SRC_TAG_EN
            ST_TAG: begin
                // Header word occupies one slot of the burst budget
                txdata_next = {24'h5A5A5A, 6'b0, grant_reg};
                txk_next    = 4'b0000;
                cnt_next    = CW'(1);
                state_next  = ST_DATA;
            end
`endif
            ST_DATA: begin
                if (xfer) begin
                    txdata_next = sel_data;
                    txk_next    = 4'b0000;
                    cnt_next    = cnt_inc;
                    if (sel_last || (cnt_inc >= CW'(MAX_BURST))) state_next = ST_GAP;
                end else begin
                    underrun_next = 1'b1;
                    state_next    = ST_GAP;
                end
            end
            default: state_next = ST_GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_GAP;
            gap_cnt_reg  <= '0;
            cnt_reg      <= '0;
            grant_reg    <= 2'd0;
            ptr_reg      <= 2'd0;
            txdata_reg   <= IDLE_WORD;
            txk_reg      <= 4'b1111;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gap_cnt_reg  <= gap_cnt_next;
            cnt_reg      <= cnt_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            txdata_reg   <= txdata_next;
            txk_reg      <= txk_next;
            underrun_reg <= underrun_next;
        end
    end

    assign txdata   = txdata_reg;
    assign txk      = txk_reg;
    assign grant_id = grant_reg;
    assign underrun = underrun_reg;
`ifdef HSST_TX_SRC_TAG_EN
    assign tx_busy  = (state_reg == ST_DATA) || (state_reg == ST_TAG);
`else
    assign tx_busy  = (state_reg == ST_DATA);
`endif

endmodule

// File: tb/tb_hsst_tx_lane_arbiter.sv
// Scoreboard bench: packet-level round-robin model predicts the lane word stream; a monitor pops and compares.
module tb_hsst_tx_lane_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int MAX_BURST = 4;
    localparam int IDLE_GAP  = 2;
    localparam logic [31:0] IDLE_W = 32'hBCBCBCBC;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [32*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_last = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           txdata;
    logic [3:0]            txk;
    logic [1:0]            grant_id;
    logic                  tx_busy;
    logic                  underrun;

    hsst_tx_lane_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .txdata(txdata), .txk(txk), .grant_id(grant_id),
        .tx_busy(tx_busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] d; logic last; int pause;} item_t;
    typedef struct {logic [31:0] d; logic [1:0] g; int gap;} exp_t;

    item_t src_q [NUM_REQ][$];
    item_t stg_q [NUM_REQ][$];
    item_t mdl_q [NUM_REQ][$];
    exp_t  exp_q [$];
    int    hold [NUM_REQ];
    int    ptr_m = 0;
    int    ur_exp = 0;
    int    ur_seen = 0;
    int    checks = 0;
    int    passes = 0;
    int    idle_run = 1000;
    bit    mon_en = 1'b0;
    logic [NUM_REQ-1:0] xfer_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic chk_ok(input string name, input bit ok, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic add_pkt(input int s, input int len, input logic [31:0] base, input bit rnd, input int pause_at);
        item_t it;
        for (int w = 0; w < len; w++) begin
            if (rnd) it.d = ($urandom_range(0, 7) == 0) ? IDLE_W : $urandom;
            else     it.d = base * (w + 1);
            it.last  = (w == len - 1);
            it.pause = (w == pause_at) ? 6 : 0;
            stg_q[s].push_back(it);
            mdl_q[s].push_back(it);
        end
    endtask

    // Packet-level reference: every source with pending words is requesting, so the
    // lane serves them round-robin, one segment per grant, split by MAX_BURST or a pause.
    task automatic schedule_round();
        int    gap_next = -1;
        int    g, limit, n;
        bit    found, done;
        item_t it;
        exp_t  e;
        forever begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && mdl_q[(ptr_m + k) % NUM_REQ].size() > 0) begin
                    found = 1'b1;
                    g = (ptr_m + k) % NUM_REQ;
                end
            end
            if (!found) break;
            limit = MAX_BURST;
`ifdef HSST_TX_SRC_TAG_EN
            e.d = {24'h5A5A5A, 6'b0, 2'(g)}; e.g = 2'(g); e.gap = gap_next;
            exp_q.push_back(e);
            gap_next = 0;
            limit = MAX_BURST - 1;
`endif
            n = 0;
            done = 1'b0;
            while (!done) begin
                it = mdl_q[g].pop_front();
                e.d = it.d; e.g = 2'(g); e.gap = gap_next;
                exp_q.push_back(e);
                gap_next = 0;
                n++;
                if (it.last || n >= limit) done = 1'b1;
                else if (mdl_q[g][0].pause > 0) begin
                    done = 1'b1;
                    ur_exp++;
                end
            end
            gap_next = (ur_exp > 0 && mdl_q[g].size() > 0 && mdl_q[g][0].pause > 0) ? -1 : IDLE_GAP + 1;
            if (gap_next == -1) begin
                it = mdl_q[g].pop_front();
                it.pause = 0;
                mdl_q[g].push_front(it);
            end
            ptr_m = (g + 1) % NUM_REQ;
        end
    endtask

    task automatic start_round();
        schedule_round();
        @(negedge clk);
        for (int s = 0; s < NUM_REQ; s++) begin
            while (stg_q[s].size() > 0) src_q[s].push_back(stg_q[s].pop_front());
        end
    endtask

    task automatic wait_round();
        int cyc = 0;
        bit busy = 1'b1;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            busy = (exp_q.size() != 0);
            for (int s = 0; s < NUM_REQ; s++) if (src_q[s].size() != 0) busy = 1'b1;
        end
        chk_ok("round_done", !busy, exp_q.size(), 0);
        if (busy) summary();
        repeat (IDLE_GAP + 6) @(negedge clk);
    endtask

    // Source drivers: hold word while valid & !ready, optional valid drop before a marked word
    initial begin
        for (int s = 0; s < NUM_REQ; s++) hold[s] = 0;
        forever begin
            @(negedge clk);
            xfer_s = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NUM_REQ; s++) begin
                item_t t;
                if (xfer_s[s] && src_q[s].size() > 0) begin
                    void'(src_q[s].pop_front());
                    if (src_q[s].size() > 0 && src_q[s][0].pause > 0) begin
                        t = src_q[s].pop_front();
                        hold[s] = t.pause;
                        t.pause = 0;
                        src_q[s].push_front(t);
                    end
                end
                if (hold[s] > 0) begin
                    hold[s]--;
                    req_valid[s] = 1'b0;
                end else if (src_q[s].size() > 0) begin
                    req_valid[s] = 1'b1;
                    req_data[32*s +: 32] = src_q[s][0].d;
                    req_last[s] = src_q[s][0].last;
                end else begin
                    req_valid[s] = 1'b0;
                    req_last[s] = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (underrun) ur_seen++;
                if (req_ready != '0) begin
                    oh = NUM_REQ'(1) << grant_id;
                    chk("ready_onehot", 32'(req_ready), 32'(oh));
                    chk("tx_busy", 32'(tx_busy), 32'd1);
                end
                if (txk == 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        chk_ok("unexpected_word", 1'b0, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txdata", txdata, e.d);
                        chk("grant_id", 32'(grant_id), 32'(e.g));
                        if (e.gap >= 0) chk_ok("gap_exact", idle_run == e.gap, idle_run, e.gap);
                        else chk_ok("gap_min", idle_run >= IDLE_GAP + 1, idle_run, IDLE_GAP + 1);
                    end
                    idle_run = 0;
                end else begin
                    chk("idle_k", 32'(txk), 32'hF);
                    chk("idle_data", txdata, IDLE_W);
                    idle_run++;
                end
            end
        end
    end

    initial begin
        int np;
        repeat (3) @(negedge clk);
        chk("rst_txdata", txdata, IDLE_W);
        chk("rst_txk", 32'(txk), 32'hF);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rstn = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);

        add_pkt(0, 3, 32'h11111111, 1'b0, -1);
        start_round(); wait_round();

        for (int p = 0; p < 4; p++) begin
            add_pkt(0, 1, 32'h0A000000 + 32'(p), 1'b0, -1);
            add_pkt(1, 1, 32'h0B000000 + 32'(p), 1'b0, -1);
        end
        start_round(); wait_round();

        add_pkt(1, 6, 32'h00C00001, 1'b0, -1);
        start_round(); wait_round();

        add_pkt(0, 5, 32'h00D00001, 1'b0, 2);
        start_round(); wait_round();

        for (int r = 0; r < 14; r++) begin
            np = 0;
            for (int s = 0; s < NUM_REQ; s++) begin
                int k = $urandom_range(0, 3);
                for (int p = 0; p < k; p++) begin
                    add_pkt(s, $urandom_range(1, 7), 32'h0, 1'b1, -1);
                    np++;
                end
            end
            if (np == 0) add_pkt(0, 2, 32'h0, 1'b1, -1);
            start_round(); wait_round();
        end

        chk("underrun_count", 32'(ur_seen), 32'(ur_exp));

        // Asynchronous reset in the middle of a packet
        add_pkt(2, 7, 32'h0, 1'b1, -1);
        start_round();
        begin
            int cyc = 0;
            while (txk != 4'b0000 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk_ok("mid_pkt_seen", txk == 4'b0000, cyc, 0);
        end
        mon_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("async_txdata", txdata, IDLE_W);
        chk("async_txk", 32'(txk), 32'hF);
        chk("async_ready", 32'(req_ready), 32'd0);
        chk("async_busy", 32'(tx_busy), 32'd0);
        summary();
    end

endmodule
